// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared definitions for the FIFO read-domain controller: buffer sizing and the
// Gray/binary pointer conversions that the write-side controller also uses.
package fifo_rd_ctrl_pkg;

    localparam int unsigned GW = 32;
    localparam logic [1:0] OUT_DEPTH = 2'd2;

    typedef enum logic [1:0] {
        SKID_IDLE = 2'b00,
        SKID_POP  = 2'b01,
        SKID_PUSH = 2'b10,
        SKID_BOTH = 2'b11
    } skid_op_e;

    // Width-independent: callers zero-extend into GW bits and truncate the result.
    function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
        logic [GW-1:0] b;
        b = g;
        for (int i = 1; i < int'(GW); i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer: absorbs the memory's one-cycle read latency so the
// read stream keeps one word per cycle while the consumer applies backpressure.
module fifo_rd_skid
    import fifo_rd_ctrl_pkg::*;
#(
    parameter int DSIZE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [DSIZE-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       out_cnt,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid
);

    logic [DSIZE-1:0] head_r;
    logic [DSIZE-1:0] tail_r;
    logic [1:0]       cnt_r;
    skid_op_e         op_s;

    assign op_s    = skid_op_e'({push, pop});
    assign out_cnt = cnt_r;
    assign m_data  = head_r;
    assign m_valid = (cnt_r != 2'd0);

    // Head/tail storage and occupancy; a push into a full buffer is refused.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r <= {DSIZE{1'b0}};
            tail_r <= {DSIZE{1'b0}};
            cnt_r  <= 2'd0;
        end else begin
            case (op_s)
                SKID_PUSH: begin
                    if (cnt_r == 2'd0) begin
                        head_r <= push_data;
                        cnt_r  <= 2'd1;
                    end else if (cnt_r == 2'd1) begin
                        tail_r <= push_data;
                        cnt_r  <= OUT_DEPTH;
                    end else begin
                        cnt_r  <= cnt_r;
                    end
                end
                SKID_POP: begin
                    head_r <= tail_r;
                    cnt_r  <= cnt_r - 2'd1;
                end
                SKID_BOTH: begin
                    if (cnt_r == OUT_DEPTH) begin
                        head_r <= tail_r;
                        tail_r <= push_data;
                    end else begin
                        head_r <= push_data;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the dual-clock FIFO: read pointer, empty/level flags,
// memory fetch control and the valid/ready output stream, all in rclk.
module fifo_rd_ctrl
    import fifo_rd_ctrl_pkg::*;
#(
    parameter int ASIZE         = 4,
    parameter int DSIZE         = 8,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [ASIZE:0]   rq2_wptr,
    output logic [ASIZE:0]   rptr,
    output logic [ASIZE-1:0] raddr,
    output logic             rd_en,
    input  logic [DSIZE-1:0] rdata_mem,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   rlevel
);

    localparam int PW = ASIZE + 1;

    logic [PW-1:0] rbin_r;
    logic [PW-1:0] rptr_r;
    logic [PW-1:0] rlevel_r;
    logic          rempty_r;
    logic          ralmost_empty_r;
    logic          inflight_r;

    logic [PW-1:0] rbin_next_s;
    logic [PW-1:0] rptr_next_s;
    logic [PW-1:0] wbin_s;
    logic [PW-1:0] level_next_s;
    logic [2:0]    occ_s;
    logic [1:0]    out_cnt_s;
    logic          fetch_s;
    logic          pop_s;

    // Fetch decision and next pointer/level; occupancy counts words already on their way.
    always_comb begin
        pop_s = m_valid & m_ready;
        occ_s = {1'b0, out_cnt_s} + {2'b00, inflight_r} - {2'b00, pop_s};
        fetch_s = ~rempty_r & (occ_s < 3'd2);
        if (fetch_s) begin
            rbin_next_s = rbin_r + PW'(1);
        end else begin
            rbin_next_s = rbin_r;
        end
        rptr_next_s  = PW'(bin2gray(GW'(rbin_next_s)));
        wbin_s       = PW'(gray2bin(GW'(rq2_wptr)));
        level_next_s = wbin_s - rbin_next_s;
    end

    // Pointer, flag and level registers.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin_r          <= {PW{1'b0}};
            rptr_r          <= {PW{1'b0}};
            rlevel_r        <= {PW{1'b0}};
            rempty_r        <= 1'b1;
            ralmost_empty_r <= 1'b1;
            inflight_r      <= 1'b0;
        end else begin
            rbin_r          <= rbin_next_s;
            rptr_r          <= rptr_next_s;
            rlevel_r        <= level_next_s;
            rempty_r        <= (rptr_next_s == rq2_wptr);
            ralmost_empty_r <= (level_next_s <= PW'(AEMPTY_THRESH));
            inflight_r      <= fetch_s;
        end
    end

    assign rd_en         = fetch_s;
    assign raddr         = rbin_r[ASIZE-1:0];
    assign rptr          = rptr_r;
    assign rlevel        = rlevel_r;
    assign rempty        = rempty_r;
    assign ralmost_empty = ralmost_empty_r;

    fifo_rd_skid #(
        .DSIZE(DSIZE)
    ) u_skid (
        .clk      (rclk),
        .rst      (rrst),
        .push     (inflight_r),
        .push_data(rdata_mem),
        .pop      (pop_s),
        .out_cnt  (out_cnt_s),
        .m_data   (m_data),
        .m_valid  (m_valid)
    );

endmodule
